sync_filter_bank: RTL and testbench

Parametrised multi-lane input conditioner: each lane passes an asynchronous or off-block input through a configurable-depth synchroniser chain, then a stability (glitch) filter, and produces a filtered level plus single-cycle rise/fall pulses. It generalises the per-slice two-flop register pair into one block with configurable lane count, chain depth, filter length and per-lane reset value. It sits at the boundary where external or foreign-domain level signals enter the `clk` domain.

---
 rtl/sync_filter_bank.sv | 107 ++++++++++
 tb/tb_sync_filter_bank.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/sync_filter_bank.sv
// sync_filter_bank: per-lane synchroniser chain, stability filter and registered rise/fall pulses.
// Optional saturating abort counter is enabled by defining SYNC_FILTER_BANK_GLITCH_CNT_EN.
module sync_filter_bank #(
    parameter int               WIDTH     = 2,
    parameter int               STAGES    = 2,
    parameter int               FILT_CNT  = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             chg
`ifdef SYNC_FILTER_BANK_GLITCH_CNT_EN
    ,
    output logic [7:0]       glitch_cnt,
    input  logic             glitch_clr
`endif
);

    localparam int            CW   = $clog2(FILT_CNT + 1);
    localparam logic [CW-1:0] LAST = CW'(FILT_CNT - 1);

    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] fire;
`ifdef SYNC_FILTER_BANK_GLITCH_CNT_EN
    logic [WIDTH-1:0] abort;
`endif

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        logic [STAGES-1:0] s;
        logic [CW-1:0]     cnt;
        logic              q_r;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                s <= {STAGES{RESET_VAL[i]}};
            end else begin
                s <= {s[STAGES-2:0], d[i]};
            end
        end

        assign y[i]    = s[STAGES-1];
        // The run of mismatches has lasted FILT_CNT cycles including this one.
        assign fire[i] = (y[i] != q_r) && (cnt == LAST);
`ifdef SYNC_FILTER_BANK_GLITCH_CNT_EN
        assign abort[i] = (y[i] == q_r) && (cnt != '0);
`endif

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt <= '0;
                q_r <= RESET_VAL[i];
            end else if (y[i] == q_r) begin
                cnt <= '0;
            end else if (fire[i]) begin
                cnt <= '0;
                q_r <= y[i];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end

        assign q[i] = q_r;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rise <= '0;
            fall <= '0;
            chg  <= 1'b0;
        end else begin
            rise <= fire & y;
            fall <= fire & ~y;
            chg  <= |fire;
        end
    end

`ifdef SYNC_FILTER_BANK_GLITCH_CNT_EN
    logic [31:0] n_abort;
    logic [31:0] sum;

    always_comb begin
        n_abort = '0;
        for (int k = 0; k < WIDTH; k++) begin
            n_abort = n_abort + 32'(abort[k]);
        end
        sum = 32'(glitch_cnt) + n_abort;
    end

    // Clear has priority over any increment landing on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            glitch_cnt <= '0;
        end else if (glitch_clr) begin
            glitch_cnt <= '0;
        end else if (sum > 32'd255) begin
            glitch_cnt <= 8'hff;
        end else begin
            glitch_cnt <= sum[7:0];
        end
    end
`endif

endmodule

// File: tb/tb_sync_filter_bank.sv
// Bench for sync_filter_bank: directed scenarios plus random lane traffic against a history-window model.
module tb_sync_filter_bank;
  localparam int               WIDTH     = 2;
  localparam int               STAGES    = 2;
  localparam int               FILT_CNT  = 4;
  localparam logic [WIDTH-1:0] RESET_VAL = 2'b10;
  localparam int               OW        = 3 * WIDTH + 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [WIDTH-1:0] d = RESET_VAL;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic             chg;
  logic             clr_drv = 1'b0;
`ifdef SYNC_FILTER_BANK_GLITCH_CNT_EN
  logic [7:0]       glitch_cnt;
`endif

  int checks = 0;
  int failures = 0;

  logic [OW-1:0]    exp_q[$];
  logic [WIDTH-1:0] d_hist[$];
  logic [WIDTH-1:0] y_hist[$];
  logic [WIDTH-1:0] m_q;
  int               since[WIDTH];
  int               m_glitch;

  sync_filter_bank #(
    .WIDTH(WIDTH), .STAGES(STAGES), .FILT_CNT(FILT_CNT), .RESET_VAL(RESET_VAL)
  ) dut (
    .clk(clk), .reset(reset), .d(d), .q(q), .rise(rise), .fall(fall), .chg(chg)
`ifdef SYNC_FILTER_BANK_GLITCH_CNT_EN
    , .glitch_cnt(glitch_cnt), .glitch_clr(clr_drv)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference model: y is d delayed by STAGES edges; q follows after FILT_CNT
  // consecutive mismatching samples since the last change of q (or reset)
  task automatic model_reset();
    d_hist.delete();
    y_hist.delete();
    for (int k = 0; k < STAGES; k++) d_hist.push_back(RESET_VAL);
    m_q = RESET_VAL;
    for (int k = 0; k < WIDTH; k++) since[k] = 0;
    m_glitch = 0;
    exp_q.delete();
    exp_q.push_back({1'b0, {WIDTH{1'b0}}, {WIDTH{1'b0}}, RESET_VAL});
  endtask

  task automatic model_step(input logic [WIDTH-1:0] dv, input logic clr);
    logic [WIDTH-1:0] ys, yprev, yw, nq, r, f;
    int ab;
    bit all_diff;
    ys = d_hist[d_hist.size() - STAGES];
    d_hist.push_back(dv);
    if (d_hist.size() > STAGES + 4) void'(d_hist.pop_front());
    y_hist.push_back(ys);
    if (y_hist.size() > FILT_CNT + 2) void'(y_hist.pop_front());
    nq = m_q; r = '0; f = '0; ab = 0;
    for (int i = 0; i < WIDTH; i++) begin
      since[i]++;
      if (y_hist.size() >= 2) begin
        yprev = y_hist[y_hist.size() - 2];
        if (ys[i] == m_q[i] && yprev[i] != m_q[i]) ab++;
      end
      if (since[i] >= FILT_CNT) begin
        all_diff = 1'b1;
        for (int j = 0; j < FILT_CNT; j++) begin
          yw = y_hist[y_hist.size() - 1 - j];
          if (yw[i] == m_q[i]) all_diff = 1'b0;
        end
        if (all_diff) begin
          nq[i] = ys[i];
          r[i] = ys[i];
          f[i] = ~ys[i];
          since[i] = 0;
        end
      end
    end
    m_q = nq;
    if (clr) m_glitch = 0;
    else m_glitch = (m_glitch + ab > 255) ? 255 : m_glitch + ab;
    exp_q.push_back({|(r | f), f, r, m_q});
  endtask

  // scoreboard
  task automatic compare();
    logic [OW-1:0] e;
    checks++;
    assert (exp_q.size() != 0) else begin
      failures++;
      $error("FAIL scoreboard observed=empty expected=entry");
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("q", 32'(q), 32'(e[WIDTH-1:0]));
      check("rise", 32'(rise), 32'(e[2*WIDTH-1:WIDTH]));
      check("fall", 32'(fall), 32'(e[3*WIDTH-1:2*WIDTH]));
      check("chg", 32'(chg), 32'(e[3*WIDTH]));
    end
`ifdef SYNC_FILTER_BANK_GLITCH_CNT_EN
    check("glitch_cnt", 32'(glitch_cnt), 32'(m_glitch));
`endif
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    if (reset) model_reset();
    else model_step(d, clr_drv);
    #1;
    compare();
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic drive(input logic [WIDTH-1:0] dv);
    d = dv;
  endtask

  initial begin
    int hold;
    model_reset();
    ticks(3);
    reset = 1'b0;

    // reset value held at the input: nothing moves
    ticks(20);
    check("rv_q", 32'(q), 32'(RESET_VAL));

    // lane 0 rises: visible after edge STAGES+FILT_CNT
    drive(2'b11);
    ticks(5);
    check("lat_q_before", 32'(q), 32'(2'b10));
    tick();
    check("lat_q", 32'(q), 32'(2'b11));
    check("lat_rise", 32'(rise), 32'(2'b01));
    check("lat_chg", 32'(chg), 32'(1));
    tick();
    check("lat_rise_end", 32'(rise), 32'(2'b00));
    check("lat_chg_end", 32'(chg), 32'(0));

    // lane 1 glitch of 3 cycles is filtered out
    drive(2'b01);
    ticks(3);
    drive(2'b11);
    for (int k = 0; k < 12; k++) begin
      tick();
      check("glitch_q1", 32'(q[1]), 32'(1));
      check("glitch_fall", 32'(fall), 32'(0));
    end
`ifdef SYNC_FILTER_BANK_GLITCH_CNT_EN
    check("glitch_one", 32'(glitch_cnt), 32'(1));
`endif

    // both lanes fall together
    drive(2'b00);
    ticks(5);
    tick();
    check("both_fall", 32'(fall), 32'(2'b11));
    check("both_chg", 32'(chg), 32'(1));
    tick();
    check("both_fall_end", 32'(fall), 32'(2'b00));
    check("both_chg_end", 32'(chg), 32'(0));

    // asynchronous reset in the middle of a count
    drive(2'b01);
    ticks(4);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    compare();
    check("ares_q", 32'(q), 32'(RESET_VAL));
    check("ares_pulses", 32'({chg, rise, fall}), 32'(0));
    ticks(2);
    reset = 1'b0;
    ticks(5);
    check("rel_q_before", 32'(q), 32'(RESET_VAL));
    tick();
    check("rel_q", 32'(q), 32'(2'b01));
    check("rel_rise", 32'(rise), 32'(2'b01));
    check("rel_fall", 32'(fall), 32'(2'b10));

    // random traffic with mixed hold lengths
    for (int n = 0; n < 120; n++) begin
      drive(WIDTH'($urandom()));
      hold = $urandom_range(1, 2 * FILT_CNT + 2);
      ticks(hold);
    end

`ifdef SYNC_FILTER_BANK_GLITCH_CNT_EN
    drive(2'b00);
    ticks(12);
    clr_drv = 1'b1;
    tick();
    clr_drv = 1'b0;
    check("clr_zero", 32'(glitch_cnt), 32'(0));
    for (int n = 0; n < 160; n++) begin
      drive(2'b11);
      tick();
      drive(2'b00);
      tick();
    end
    check("sat_255", 32'(glitch_cnt), 32'(255));
    drive(2'b11);
    clr_drv = 1'b1;
    tick();
    drive(2'b00);
    tick();
    check("clr_wins", 32'(glitch_cnt), 32'(0));
    clr_drv = 1'b0;
    ticks(8);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
